// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared types and default sizes for the banked vector stream memory
package vec_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } vm_state_e;

    typedef enum logic {
        VM_READ  = 1'b0,
        VM_WRITE = 1'b1
    } vm_mode_e;

    localparam int VM_NUM_BANKS = 4;
    localparam int VM_DATA_W    = 4096;
    localparam int VM_DEPTH     = 16;

endpackage

// File: rtl/vec_bank_ram.sv
// rtl/vec_bank_ram.sv - single-port synchronous bank RAM, read returns old data on a same-cycle write
module vec_bank_ram #(
    parameter int W      = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage is never cleared; only the read register sees reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/vec_bank_stream_mem.sv
// rtl/vec_bank_stream_mem.sv - multi-bank vector memory with burst row streaming
// Optional per-bank parity storage and checking: define VEC_MEM_PARITY_EN.
module vec_bank_stream_mem
    import vec_mem_pkg::*;
#(
    parameter int NUM_BANKS = VM_NUM_BANKS,
    parameter int DATA_W    = VM_DATA_W,
    parameter int DEPTH     = VM_DEPTH,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int LEN_W    = ADDR_W + 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              mode,
    input  logic [ADDR_W-1:0]                 base_addr,
    input  logic [LEN_W-1:0]                  length,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0]  wr_data,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    output logic [NUM_BANKS-1:0][DATA_W-1:0]  rd_data,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic                              busy,
    output logic                              done,
    output logic [NUM_BANKS-1:0]              par_err
);

`ifdef VEC_MEM_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif

    vm_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic              rd_valid_q;
    logic              zero_done_q;
    logic              we, re;

    always_comb begin
        state_d  = state_q;
        we       = 1'b0;
        re       = 1'b0;
        wr_ready = 1'b0;
        done     = zero_done_q;
        case (state_q)
            IDLE: begin
                if (start && length != '0) begin
                    state_d = (vm_mode_e'(mode) == VM_WRITE) ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    we = 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end
            end
            READ: begin
                if ((!rd_valid_q || rd_ready) && rem_q != '0) begin
                    re = 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rd_valid_q && rd_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A beat presented in the reset cycle must neither land nor complete the burst.
        if (reset) begin
            we       = 1'b0;
            re       = 1'b0;
            wr_ready = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            rd_valid_q  <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= (state_q == IDLE) && start && (length == '0);
            if (state_q == IDLE && start) begin
                addr_q <= base_addr;
                rem_q  <= length;
            end else if (we || re) begin
                addr_q <= addr_q + ADDR_W'(1);
                rem_q  <= rem_q - LEN_W'(1);
            end
            if (re) begin
                rd_valid_q <= 1'b1;
            end else if (rd_ready) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign rd_valid = rd_valid_q;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [RAM_W-1:0] wword;
        logic [RAM_W-1:0] rword;

`ifdef VEC_MEM_PARITY_EN
        assign wword      = {^wr_data[b], wr_data[b]};
        assign par_err[b] = rd_valid_q && ((^rword[DATA_W-1:0]) != rword[DATA_W]);
`else
        assign wword      = wr_data[b];
        assign par_err[b] = 1'b0;
`endif
        assign rd_data[b] = rword[DATA_W-1:0];

        vec_bank_ram #(
            .W      (RAM_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .we    (we),
            .re    (re),
            .addr  (addr_q),
            .wdata (wword),
            .rdata (rword)
        );
    end

endmodule

// File: tb/tb_vec_bank_stream_mem.sv
// tb/tb_vec_bank_stream_mem.sv - directed self-checking bench for vec_bank_stream_mem
module tb_vec_bank_stream_mem;

    localparam int NB    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    typedef logic [NB-1:0][DW-1:0] row_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mode;
    logic [3:0]  base_addr;
    logic [4:0]  length;
    row_t        wr_data;
    logic        wr_valid;
    logic        wr_ready;
    row_t        rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        busy;
    logic        done;
    logic [NB-1:0] par_err;

    int n_checks = 0;
    int n_fail   = 0;

    row_t          exp_rows [16];
    logic [NB-1:0] exp_par  [16];

    vec_bank_stream_mem #(
        .NUM_BANKS (NB),
        .DATA_W    (DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .length    (length),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .done      (done),
        .par_err   (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bank b of beat k carries off + b*16 + k.
    function automatic row_t row(input logic [15:0] off, input int beat);
        row_t r;
        for (int b = 0; b < NB; b++) begin
            r[b] = off + 16'(b * 16 + beat);
        end
        return r;
    endfunction

    task automatic do_write(input int base, input int len, input logic [15:0] off);
        @(negedge clk);
        start = 1'b1; mode = 1'b1; base_addr = 4'(base); length = 5'(len);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = row(off, i);
            #1;
            check("wr_ready", 64'(wr_ready), 64'd1);
            check("wr_done", 64'(done), 64'(i == len - 1));
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        check("wr_end_busy", 64'(busy), 64'd0);
        check("wr_end_ready", 64'(wr_ready), 64'd0);
    endtask

    task automatic do_read(input int base, input int len, input logic [63:0] stall, input int exp_last);
        int   k;
        int   last_idx;
        logic prev_stall;
        row_t prev_data;
        k = 0; last_idx = -1; prev_stall = 1'b0; prev_data = '0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base_addr = 4'(base); length = 5'(len); rd_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int idx = 0; idx < 40; idx++) begin
            if (idx > 0) @(negedge clk);
            rd_ready = !stall[idx];
            #1;
            if (prev_stall) begin
                check("rd_hold_valid", 64'(rd_valid), 64'd1);
                check("rd_hold_data", 64'(rd_data), 64'(prev_data));
            end
            if (rd_valid && rd_ready) begin
                check("rd_data", 64'(rd_data), 64'(exp_rows[k]));
                check("rd_par", 64'(par_err), 64'(exp_par[k]));
                check("rd_done", 64'(done), 64'(k == len - 1));
                last_idx = idx;
                k++;
            end else begin
                check("rd_no_done", 64'(done), 64'd0);
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            if (k == len) break;
        end
        check("rd_accepts", 64'(k), 64'(len));
        check("rd_last_cycle", 64'(last_idx), 64'(exp_last));
        @(negedge clk);
        rd_ready = 1'b1;
        #1;
        check("rd_end_valid", 64'(rd_valid), 64'd0);
        check("rd_end_busy", 64'(busy), 64'd0);
        check("rd_end_done", 64'(done), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; length = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) exp_par[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_par_err", 64'(par_err), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic write then full-throughput read
        do_write(2, 4, 16'h0000);
        for (int i = 0; i < 4; i++) exp_rows[i] = row(16'h0000, i);
        do_read(2, 4, 64'd0, 4);

        // Address wrap at DEPTH-1
        do_write(15, 3, 16'h0200);
        for (int i = 0; i < 3; i++) exp_rows[i] = row(16'h0200, i);
        do_read(15, 3, 64'd0, 3);
        exp_rows[0] = row(16'h0200, 1);
        exp_rows[1] = row(16'h0200, 2);
        do_read(0, 2, 64'd0, 2);

        // Backpressure on cycles 2-3
        for (int i = 0; i < 4; i++) exp_rows[i] = row(16'h0000, i);
        do_read(2, 4, 64'h0000_0000_0000_000C, 6);

        // Zero-length burst
        @(negedge clk);
        start = 1'b1; mode = 1'b1; base_addr = 4'd2; length = 5'd0;
        wr_valid = 1'b1; wr_data = row(16'h0F00, 0);
        #1;
        check("zl_done_early", 64'(done), 64'd0);
        check("zl_busy0", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("zl_done", 64'(done), 64'd1);
        check("zl_busy1", 64'(busy), 64'd0);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        check("zl_done_gone", 64'(done), 64'd0);
        do_read(2, 4, 64'd0, 4);

        // Reset in the middle of a 6-beat write, with a stray start while busy
        do_write(8, 6, 16'h0800);
        @(negedge clk);
        start = 1'b1; mode = 1'b1; base_addr = 4'd8; length = 5'd6;
        @(negedge clk);
        start = 1'b0; wr_valid = 1'b1; wr_data = row(16'h0400, 0);
        @(negedge clk);
        wr_data = row(16'h0400, 1);
        start = 1'b1; mode = 1'b0; base_addr = 4'd0; length = 5'd1;
        #1;
        check("mid_busy", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0; wr_data = row(16'h0400, 2); reset = 1'b1;
        #1;
        check("mid_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0; wr_valid = 1'b0;
        #1;
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_done", 64'(done), 64'd0);
        check("post_rst_rd_valid", 64'(rd_valid), 64'd0);
        exp_rows[0] = row(16'h0400, 0);
        exp_rows[1] = row(16'h0400, 1);
        for (int i = 2; i < 6; i++) exp_rows[i] = row(16'h0800, i);
        do_read(8, 6, 64'd0, 6);

`ifdef VEC_MEM_PARITY_EN
        // Corrupt one stored data bit in bank 1 at address 2
        dut.g_bank[1].u_ram.mem[2][0] = ~dut.g_bank[1].u_ram.mem[2][0];
        exp_rows[0]    = row(16'h0000, 0);
        exp_rows[0][1] = exp_rows[0][1] ^ 16'h0001;
        exp_rows[1]    = row(16'h0000, 1);
        exp_par[0]     = 4'b0010;
        exp_par[1]     = 4'b0000;
        do_read(2, 2, 64'd0, 2);
        exp_par[0]     = 4'b0000;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
